// File: rtl/pong_match_ctrl_if.sv
// Bundle of the match controller's game-facing signals: slow tick, debounced
// buttons and miss pulses in; match state, scores and ball gating out.
interface pong_match_ctrl_if #(
  parameter int SCORE_W = 4
);
  logic               tick;
  logic               btn_up;
  logic               btn_down;
  logic               btn_start;
  logic               miss_p1;
  logic               miss_p2;
  logic [1:0]         state;
  logic [SCORE_W-1:0] max_score;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic               serve_side;
  logic               ball_en;
  logic               launch;
  logic               winner;

  // Game environment side: drives the tick/buttons/misses, observes the match.
  modport master (
    output tick, btn_up, btn_down, btn_start, miss_p1, miss_p2,
    input  state, max_score, score1, score2, serve_side, ball_en, launch, winner
  );

  // Match controller side.
  modport slave (
    input  tick, btn_up, btn_down, btn_start, miss_p1, miss_p2,
    output state, max_score, score1, score2, serve_side, ball_en, launch, winner
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: max-score setting in SETUP, then SERVE -> PLAY -> WIN
// flow with both players' scores. Every output is a register updated on clk.
module pong_match_ctrl #(
  parameter int SCORE_W     = 4,
  parameter int MAX_LIMIT   = 9,
  parameter int DEFAULT_MAX = 5,
  parameter int SERVE_TICKS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  pong_match_ctrl_if.slave    bus
);

  localparam logic [1:0] ST_SETUP = 2'd0;
  localparam logic [1:0] ST_SERVE = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;
  localparam logic [1:0] ST_WIN   = 2'd3;

  // The counter only needs to reach SERVE_TICKS-1; the final tick launches.
  localparam int CNT_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SERVE_TICKS - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(MAX_LIMIT);
  localparam logic [SCORE_W-1:0] SCORE_DEF = SCORE_W'(DEFAULT_MAX);
  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

  logic               up_prev;
  logic               down_prev;
  logic               start_prev;
  logic [CNT_W-1:0]   tick_cnt;

  logic               up_evt;
  logic               down_evt;
  logic               start_evt;
  logic [SCORE_W-1:0] score1_inc;
  logic [SCORE_W-1:0] score2_inc;

  // Rising-edge events so a held button counts once; incremented scores are
  // compared against max_score in the same edge that stores them.
  always_comb begin
    up_evt     = bus.btn_up    & ~up_prev;
    down_evt   = bus.btn_down  & ~down_prev;
    start_evt  = bus.btn_start & ~start_prev;
    score1_inc = bus.score1 + SCORE_ONE;
    score2_inc = bus.score2 + SCORE_ONE;
  end

  // Match state machine, score keeping, serve countdown and button history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.state      <= ST_SETUP;
      bus.max_score  <= SCORE_DEF;
      bus.score1     <= '0;
      bus.score2     <= '0;
      bus.serve_side <= 1'b0;
      bus.ball_en    <= 1'b0;
      bus.launch     <= 1'b0;
      bus.winner     <= 1'b0;
      tick_cnt       <= '0;
      up_prev        <= 1'b0;
      down_prev      <= 1'b0;
      start_prev     <= 1'b0;
    end else begin
      up_prev    <= bus.btn_up;
      down_prev  <= bus.btn_down;
      start_prev <= bus.btn_start;
      bus.launch <= 1'b0;

      case (bus.state)
        ST_SETUP: begin
          bus.ball_en <= 1'b0;
          if (start_evt) begin
            // Start takes priority over a simultaneous up/down press.
            bus.state      <= ST_SERVE;
            bus.score1     <= '0;
            bus.score2     <= '0;
            bus.serve_side <= 1'b0;
            tick_cnt       <= '0;
          end else if (up_evt && !down_evt) begin
            if (bus.max_score < SCORE_MAX) bus.max_score <= bus.max_score + SCORE_ONE;
          end else if (down_evt && !up_evt) begin
            if (bus.max_score > SCORE_ONE) bus.max_score <= bus.max_score - SCORE_ONE;
          end
        end

        ST_SERVE: begin
          bus.ball_en <= 1'b0;
          if (bus.tick) begin
            if (tick_cnt == CNT_LAST) begin
              bus.state   <= ST_PLAY;
              bus.ball_en <= 1'b1;
              bus.launch  <= 1'b1;
              tick_cnt    <= '0;
            end else begin
              tick_cnt <= tick_cnt + CNT_W'(1);
            end
          end
        end

        ST_PLAY: begin
          if (bus.miss_p1 && bus.miss_p2) begin
            // Let: replay the point from the same side, no score.
            bus.state   <= ST_SERVE;
            bus.ball_en <= 1'b0;
          end else if (bus.miss_p1) begin
            bus.score2  <= score2_inc;
            bus.ball_en <= 1'b0;
            if (score2_inc == bus.max_score) begin
              bus.state  <= ST_WIN;
              bus.winner <= 1'b1;
            end else begin
              bus.state      <= ST_SERVE;
              bus.serve_side <= 1'b0;
            end
          end else if (bus.miss_p2) begin
            bus.score1  <= score1_inc;
            bus.ball_en <= 1'b0;
            if (score1_inc == bus.max_score) begin
              bus.state  <= ST_WIN;
              bus.winner <= 1'b0;
            end else begin
              bus.state      <= ST_SERVE;
              bus.serve_side <= 1'b1;
            end
          end
        end

        ST_WIN: begin
          // Scores stay on display; the next start from SETUP clears them.
          bus.ball_en <= 1'b0;
          if (start_evt) bus.state <= ST_SETUP;
        end

        default: begin
          bus.state   <= ST_SETUP;
          bus.ball_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl: max-score buttons, serve countdown,
// scoring, let, win/restart and asynchronous reset.
module tb_pong_match_ctrl;

  localparam int SCORE_W     = 4;
  localparam int SERVE_TICKS = 3;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  pong_match_ctrl_if #(.SCORE_W(SCORE_W)) bus ();

  pong_match_ctrl #(
    .SCORE_W    (SCORE_W),
    .MAX_LIMIT  (9),
    .DEFAULT_MAX(5),
    .SERVE_TICKS(SERVE_TICKS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_up();
    bus.btn_up = 1'b1; step(); bus.btn_up = 1'b0; step();
  endtask

  task automatic press_down();
    bus.btn_down = 1'b1; step(); bus.btn_down = 1'b0; step();
  endtask

  task automatic press_start();
    bus.btn_start = 1'b1; step(); bus.btn_start = 1'b0; step();
  endtask

  // Issue SERVE_TICKS tick pulses; returns right after the launching edge.
  task automatic do_serve(input string tag);
    for (int i = 0; i < SERVE_TICKS; i++) begin
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
      if (i < SERVE_TICKS - 1) begin
        check_val({tag, "_serving"}, int'(bus.state), 1);
        step();
      end
    end
    check_val({tag, "_play"}, int'(bus.state), 2);
    check_val({tag, "_launch"}, int'(bus.launch), 1);
    check_val({tag, "_ball_en"}, int'(bus.ball_en), 1);
  endtask

  task automatic pulse_miss(input logic p1, input logic p2);
    bus.miss_p1 = p1; bus.miss_p2 = p2; step();
    bus.miss_p1 = 1'b0; bus.miss_p2 = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n         = 1'b0;
    bus.tick      = 1'b0;
    bus.btn_up    = 1'b0;
    bus.btn_down  = 1'b0;
    bus.btn_start = 1'b0;
    bus.miss_p1   = 1'b0;
    bus.miss_p2   = 1'b0;
    step(); step();

    check_val("rst_state", int'(bus.state), 0);
    check_val("rst_max", int'(bus.max_score), 5);
    check_val("rst_s1", int'(bus.score1), 0);
    check_val("rst_s2", int'(bus.score2), 0);
    check_val("rst_launch", int'(bus.launch), 0);
    check_val("rst_ball_en", int'(bus.ball_en), 0);
    rst_n = 1'b1;
    step();

    // Max-score setting and saturation.
    press_up();
    check_val("max_up1", int'(bus.max_score), 6);
    for (int i = 0; i < 5; i++) press_up();
    check_val("max_sat_hi", int'(bus.max_score), 9);
    for (int i = 0; i < 10; i++) press_down();
    check_val("max_sat_lo", int'(bus.max_score), 1);
    bus.btn_up = 1'b1; bus.btn_down = 1'b1; step();
    bus.btn_up = 1'b0; bus.btn_down = 1'b0; step();
    check_val("max_updown", int'(bus.max_score), 1);
    press_up();
    check_val("max_up2", int'(bus.max_score), 2);

    // Held button counts once.
    bus.btn_up = 1'b1;
    for (int i = 0; i < 100; i++) step();
    bus.btn_up = 1'b0; step();
    check_val("max_hold", int'(bus.max_score), 3);

    // Start, serve countdown, launch pulse.
    bus.btn_start = 1'b1; step();
    check_val("start_serve", int'(bus.state), 1);
    check_val("start_ball_en", int'(bus.ball_en), 0);
    bus.btn_start = 1'b0; step();
    do_serve("srv1");
    step();
    check_val("launch_once", int'(bus.launch), 0);
    check_val("still_play", int'(bus.state), 2);

    // Start and up are ignored during PLAY.
    press_start();
    press_up();
    check_val("start_in_play", int'(bus.state), 2);
    check_val("up_in_play", int'(bus.max_score), 3);

    // P1 misses: P2 scores, P1 serves next.
    pulse_miss(1'b1, 1'b0);
    check_val("p1miss_s2", int'(bus.score2), 1);
    check_val("p1miss_state", int'(bus.state), 1);
    check_val("p1miss_side", int'(bus.serve_side), 0);
    check_val("p1miss_ball_en", int'(bus.ball_en), 0);

    // Misses while serving are ignored.
    pulse_miss(1'b0, 1'b1);
    pulse_miss(1'b1, 1'b0);
    check_val("serve_miss_s1", int'(bus.score1), 0);
    check_val("serve_miss_s2", int'(bus.score2), 1);
    step();

    do_serve("srv2");
    pulse_miss(1'b0, 1'b1);
    check_val("p2miss_s1", int'(bus.score1), 1);
    check_val("p2miss_side", int'(bus.serve_side), 1);
    check_val("p2miss_state", int'(bus.state), 1);
    step();

    // Let: both miss together.
    do_serve("srv3");
    pulse_miss(1'b1, 1'b1);
    check_val("let_s1", int'(bus.score1), 1);
    check_val("let_s2", int'(bus.score2), 1);
    check_val("let_state", int'(bus.state), 1);
    check_val("let_side", int'(bus.serve_side), 1);
    step();

    // P2 reaches 3 = max_score.
    do_serve("srv4");
    pulse_miss(1'b1, 1'b0);
    check_val("s2_two", int'(bus.score2), 2);
    check_val("s2_two_state", int'(bus.state), 1);
    step();
    do_serve("srv5");
    pulse_miss(1'b1, 1'b0);
    check_val("win3_state", int'(bus.state), 3);
    check_val("win3_winner", int'(bus.winner), 1);
    check_val("win3_s2", int'(bus.score2), 3);
    check_val("win3_ball_en", int'(bus.ball_en), 0);
    step();

    // WIN -> SETUP keeps max_score and scores; lower max to 2.
    press_start();
    check_val("setup_state", int'(bus.state), 0);
    check_val("setup_max", int'(bus.max_score), 3);
    check_val("setup_s2_kept", int'(bus.score2), 3);
    press_down();
    check_val("max_to2", int'(bus.max_score), 2);
    bus.btn_start = 1'b1; step();
    bus.btn_start = 1'b0;
    check_val("restart_s1", int'(bus.score1), 0);
    check_val("restart_s2", int'(bus.score2), 0);
    check_val("restart_side", int'(bus.serve_side), 0);
    step();

    // Max 2: P2 scores twice and wins.
    do_serve("m2a");
    pulse_miss(1'b1, 1'b0);
    check_val("m2_s2_1", int'(bus.score2), 1);
    step();
    do_serve("m2b");
    pulse_miss(1'b1, 1'b0);
    check_val("m2_win", int'(bus.state), 3);
    check_val("m2_winner", int'(bus.winner), 1);
    check_val("m2_ball_en", int'(bus.ball_en), 0);
    step();
    press_start();
    check_val("m2_setup", int'(bus.state), 0);
    check_val("m2_setup_max", int'(bus.max_score), 2);

    // New match, then asynchronous reset in the middle of PLAY.
    press_start();
    do_serve("rsta");
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_state", int'(bus.state), 0);
    check_val("arst_max", int'(bus.max_score), 5);
    check_val("arst_ball_en", int'(bus.ball_en), 0);
    check_val("arst_launch", int'(bus.launch), 0);
    check_val("arst_s1", int'(bus.score1), 0);
    check_val("arst_s2", int'(bus.score2), 0);
    check_val("arst_side", int'(bus.serve_side), 0);
    check_val("arst_winner", int'(bus.winner), 0);
    step();
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
